// File: rtl/uart_pkg.sv
// Shared UART receive definitions: data width, parity modes, FSM encoding,
// the completed-frame payload and the parity check helper.
package uart_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 3;

    // Parity mode values for the PARITY parameter
    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // Byte plus its status flags, presented to the consumer as one unit
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              parity_err;
        logic              frame_err;
    } rx_frame_t;

    // High when data plus parity bit disagree with the selected parity mode
    function automatic logic parity_err_f(input logic [DATA_W-1:0] data,
                                          input logic              pbit,
                                          input int unsigned       mode);
        return (^data) ^ pbit ^ logic'(mode == PARITY_ODD);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus falling-edge
// detect on the synchronized value.
// Ports:
//   uart_clk, uart_rst_p : clock, async active-high reset (flops reset to idle-high)
//   rx_i                 : raw serial line
//   rx_s_o               : synchronized line
//   rx_fall_c_o          : rx_d high and rx_s low (start-bit edge), combinational
module uart_rx_sync (
    input  logic uart_clk,
    input  logic uart_rst_p,
    input  logic rx_i,
    output logic rx_s_o,
    output logic rx_fall_c_o
);

    logic meta_q;
    logic rx_s_q;
    logic rx_d_q;

    // Synchronizer chain and one-cycle delayed copy
    always_ff @(posedge uart_clk or posedge uart_rst_p) begin
        if (uart_rst_p) begin
            meta_q <= 1'b1;
            rx_s_q <= 1'b1;
            rx_d_q <= 1'b1;
        end else begin
            meta_q <= rx_i;
            rx_s_q <= meta_q;
            rx_d_q <= rx_s_q;
        end
    end

    assign rx_s_o      = rx_s_q;
    // A line held low never produces a second edge
    assign rx_fall_c_o = rx_d_q & ~rx_s_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start detect, bit sampling on external mid-bit
// ticks, optional parity, stop check, and a valid/ready output holding
// register with sticky overrun.
// Ports:
//   uart_clk, uart_rst_p : clock, async active-high reset
//   rx_in                : serial line (asynchronous, idle high)
//   rx_baud_clk          : one-cycle mid-bit sample tick
//   rx_clk_en            : baud counter enable, high whenever a frame is in progress
//   rx_data              : received byte
//   rx_valid / rx_ready  : output handshake
//   rx_parity_err        : parity mismatch on rx_data
//   rx_frame_err         : stop bit was low for rx_data
//   rx_overrun           : sticky, an unconsumed byte was overwritten
//   rx_busy              : FSM not idle
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned PARITY     = PARITY_NONE,
    parameter int unsigned STOP_CHECK = 1
) (
    input  logic              uart_clk,
    input  logic              uart_rst_p,
    input  logic              rx_in,
    input  logic              rx_baud_clk,
    output logic              rx_clk_en,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              rx_overrun,
    output logic              rx_busy
);

    logic rx_s;
    logic rx_fall_c;

    uart_rx_sync u_sync (
        .uart_clk    (uart_clk),
        .uart_rst_p  (uart_rst_p),
        .rx_i        (rx_in),
        .rx_s_o      (rx_s),
        .rx_fall_c_o (rx_fall_c)
    );

    rx_state_e         state_q,   state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] shift_q,   shift_d;
    logic              perr_q,    perr_d;
    rx_frame_t         out_q,     out_d;
    logic              valid_q,   valid_d;
    logic              ovr_q,     ovr_d;
    logic              clk_en_q,  clk_en_d;
    logic              busy_q,    busy_d;

    logic handshake_c;
    logic frame_done_c;

    // Register bank
    always_ff @(posedge uart_clk or posedge uart_rst_p) begin
        if (uart_rst_p) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            out_q     <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            clk_en_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            clk_en_q  <= clk_en_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state, datapath and output holding logic
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        out_d        = out_q;
        valid_d      = valid_q;
        ovr_d        = ovr_q;
        frame_done_c = 1'b0;
        handshake_c  = valid_q & rx_ready;

        unique case (state_q)
            ST_IDLE: begin
                if (rx_fall_c) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_baud_clk) begin
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        perr_d    = 1'b0;
                    end else begin
                        // Glitch shorter than half a bit: false start
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                if (rx_baud_clk) begin
                    shift_d   = {rx_s, shift_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (rx_baud_clk) begin
                    perr_d  = parity_err_f(shift_q, rx_s, PARITY);
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (rx_baud_clk) begin
                    frame_done_c = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (handshake_c) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end

        // A completion always wins; it is an overrun only if the old byte was not taken
        if (frame_done_c) begin
            out_d.data       = shift_q;
            out_d.parity_err = perr_q;
            out_d.frame_err  = (STOP_CHECK != 0) && !rx_s;
            valid_d          = 1'b1;
            if (valid_q && !handshake_c) begin
                ovr_d = 1'b1;
            end
        end

        clk_en_d = (state_d != ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
    end

    assign rx_clk_en     = clk_en_q;
    assign rx_busy       = busy_q;
    assign rx_data       = out_q.data;
    assign rx_parity_err = out_q.parity_err;
    assign rx_frame_err  = out_q.frame_err;
    assign rx_valid      = valid_q;
    assign rx_overrun    = ovr_q;

endmodule
